// File: rtl/manycore_rom_endpoint_pkg.sv
// Shared constants and helpers for the manycore ROM endpoint.
package manycore_rom_endpoint_pkg;

  localparam int unsigned byte_width_lp = 8;

  // clog2 that never returns 0, so a 1-deep structure still gets a 1-bit index
  function automatic int clog2_safe(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/manycore_rom_array.sv
// Asynchronous-read ROM. Contents come from a packed constant, word 0 in the LSBs.
// Indices past the last word (non-power-of-two depth) read as zero.
module manycore_rom_array
  import manycore_rom_endpoint_pkg::*;
#(
  parameter int word_width_p = 32,
  parameter int word_count_p = 256,
  parameter logic [word_width_p*word_count_p-1:0] init_p = '0,
  localparam int lg_count_lp = clog2_safe(word_count_p)
) (
  input  logic [lg_count_lp-1:0]  addr_i,
  output logic [word_width_p-1:0] data_o
);

  localparam logic [lg_count_lp:0] count_ext_lp = (lg_count_lp + 1)'(word_count_p);

  logic [word_width_p-1:0] rom_mem [word_count_p];

  for (genvar gi = 0; gi < word_count_p; gi++) begin : g_word
    assign rom_mem[gi] = init_p[gi*word_width_p +: word_width_p];
  end

  // Combinational lookup with out-of-range indices forced to zero
  always_comb begin
    data_o = '0;
    if ({1'b0, addr_i} < count_ext_lp) begin
      data_o = rom_mem[addr_i];
    end
  end

endmodule

// File: rtl/manycore_rom_endpoint.sv
// Read-only network slave: request FIFO feeding a ROM lookup and a single
// response register. Writes are dropped and flagged on a sticky error bit.
module manycore_rom_endpoint
  import manycore_rom_endpoint_pkg::*;
#(
  parameter int    rom_width_p    = 32,
  parameter int    rom_els_p      = 256,
  parameter string rom_filename_p = "rom.mem",
  parameter logic [rom_width_p*rom_els_p-1:0] rom_init_p = '0,
  parameter int    x_cord_width_p = 6,
  parameter int    y_cord_width_p = 5,
  parameter int    addr_width_p   = 28,
  parameter int    data_width_p   = 32,
  parameter int    fifo_els_p     = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [x_cord_width_p-1:0]   my_x_i,
  input  logic [y_cord_width_p-1:0]   my_y_i,
  input  logic                        req_v_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [addr_width_p-1:0]     req_addr_i,
  input  logic [data_width_p-1:0]     req_data_i,
  input  logic [data_width_p/8-1:0]   req_mask_i,
  input  logic [x_cord_width_p-1:0]   req_src_x_i,
  input  logic [y_cord_width_p-1:0]   req_src_y_i,
  output logic                        resp_v_o,
  input  logic                        resp_ready_i,
  output logic [data_width_p-1:0]     resp_data_o,
  output logic [x_cord_width_p-1:0]   resp_dst_x_o,
  output logic [y_cord_width_p-1:0]   resp_dst_y_o,
  output logic                        wr_err_o
);

  localparam int lg_rom_els_lp  = clog2_safe(rom_els_p);
  localparam int lg_fifo_els_lp = clog2_safe(fifo_els_p);
  localparam int mask_width_lp  = data_width_p / byte_width_lp;

  typedef logic [lg_fifo_els_lp-1:0] ptr_t;
  typedef logic [lg_fifo_els_lp:0]   cnt_t;

  localparam ptr_t last_ptr_lp   = ptr_t'(fifo_els_p - 1);
  localparam cnt_t full_count_lp = cnt_t'(fifo_els_p);

  typedef struct packed {
    logic                      we;
    logic [addr_width_p-1:0]   addr;
    logic [mask_width_lp-1:0]  mask;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] src_y;
  } req_entry_s;

  if (rom_width_p > data_width_p) begin : g_err_rom_width
    $error("rom_width_p must not exceed data_width_p");
  end
  if ((data_width_p % byte_width_lp) != 0) begin : g_err_data_width
    $error("data_width_p must be a multiple of 8");
  end
  if (addr_width_p < lg_rom_els_lp) begin : g_err_addr_width
    $error("addr_width_p too narrow for rom_els_p");
  end
  if (fifo_els_p < 2) begin : g_err_fifo_els
    $error("fifo_els_p must be at least 2");
  end

  req_entry_s fifo_mem_q [fifo_els_p];
  ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t       count_q, count_d;
  req_entry_s enq_entry, head_entry;
  logic       enq, deq, head_v;

  logic                      resp_v_q, resp_v_d;
  logic [data_width_p-1:0]   resp_data_q, resp_data_d;
  logic [x_cord_width_p-1:0] resp_x_q, resp_x_d;
  logic [y_cord_width_p-1:0] resp_y_q, resp_y_d;
  logic                      wr_err_q, wr_err_d;

  logic [rom_width_p-1:0]  rom_word;
  logic [data_width_p-1:0] rom_word_ext, masked_data;

  // Debug coordinates, write data and upper address bits carry no function here
  logic unused_inputs;
  assign unused_inputs = ^{my_x_i, my_y_i, req_data_i, head_entry.addr};

  // Ready reflects the full state before any same-cycle dequeue
  assign req_ready_o = (count_q != full_count_lp);
  assign enq         = req_v_i & req_ready_o;
  assign head_v      = (count_q != '0);
  assign head_entry  = fifo_mem_q[rd_ptr_q];
  assign deq         = head_v & (~resp_v_q | resp_ready_i);

  // Pack the incoming request into a FIFO entry
  always_comb begin
    enq_entry       = '0;
    enq_entry.we    = req_we_i;
    enq_entry.addr  = req_addr_i;
    enq_entry.mask  = req_mask_i;
    enq_entry.src_x = req_src_x_i;
    enq_entry.src_y = req_src_y_i;
  end

  // FIFO payload storage; only control state needs reset
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_mem_q[wr_ptr_q] <= enq_entry;
    end
  end

  // Next pointers and occupancy, wrapping at the configured depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_t'(1);
    if (deq) rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_t'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  manycore_rom_array #(
    .word_width_p (rom_width_p),
    .word_count_p (rom_els_p),
    .init_p       (rom_init_p)
  ) rom (
    .addr_i (head_entry.addr[lg_rom_els_lp-1:0]),
    .data_o (rom_word)
  );

  assign rom_word_ext = data_width_p'(rom_word);

  for (genvar gi = 0; gi < mask_width_lp; gi++) begin : g_mask
    assign masked_data[gi*byte_width_lp +: byte_width_lp] =
      head_entry.mask[gi] ? rom_word_ext[gi*byte_width_lp +: byte_width_lp] : 8'h00;
  end

  // Response slot: drain on handshake, load on a read dequeue, flag writes
  always_comb begin
    resp_v_d    = resp_v_q;
    resp_data_d = resp_data_q;
    resp_x_d    = resp_x_q;
    resp_y_d    = resp_y_q;
    wr_err_d    = wr_err_q;
    if (resp_v_q & resp_ready_i) begin
      resp_v_d = 1'b0;
    end
    if (deq) begin
      if (head_entry.we) begin
        wr_err_d = 1'b1;
      end else begin
        resp_v_d    = 1'b1;
        resp_data_d = masked_data;
        resp_x_d    = head_entry.src_x;
        resp_y_d    = head_entry.src_y;
      end
    end
  end

  // Control and response registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      resp_x_q    <= '0;
      resp_y_q    <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
      resp_x_q    <= resp_x_d;
      resp_y_q    <= resp_y_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign resp_v_o     = resp_v_q;
  assign resp_data_o  = resp_data_q;
  assign resp_dst_x_o = resp_x_q;
  assign resp_dst_y_o = resp_y_q;
  assign wr_err_o     = wr_err_q;

endmodule

// File: tb/tb_manycore_rom_endpoint.sv
// Directed bench for manycore_rom_endpoint: table of single reads plus
// hand-written back-to-back, backpressure, write and async-reset sequences.
module tb_manycore_rom_endpoint;

  localparam int XW = 6;
  localparam int YW = 5;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  localparam logic [32*256-1:0] ROM_INIT =
    {{(252*32){1'b0}}, 32'h0000_0000, 32'hDEAD_BEEF, 32'h5566_7788, 32'h1122_3344};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [XW-1:0] my_x;
  logic [YW-1:0] my_y;
  logic          req_v, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [MW-1:0] req_mask;
  logic [XW-1:0] req_src_x;
  logic [YW-1:0] req_src_y;
  logic          resp_v, resp_ready;
  logic [DW-1:0] resp_data;
  logic [XW-1:0] resp_dst_x;
  logic [YW-1:0] resp_dst_y;
  logic          wr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  manycore_rom_endpoint #(
    .rom_init_p (ROM_INIT)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .my_x_i       (my_x),
    .my_y_i       (my_y),
    .req_v_i      (req_v),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_mask_i   (req_mask),
    .req_src_x_i  (req_src_x),
    .req_src_y_i  (req_src_y),
    .resp_v_o     (resp_v),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_dst_x_o (resp_dst_x),
    .resp_dst_y_o (resp_dst_y),
    .wr_err_o     (wr_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] exp;
  } vec_s;

  vec_s vecs [8];
  vec_s bp   [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_read(input vec_s v);
    req_v     = 1'b1;
    req_we    = 1'b0;
    req_addr  = v.addr;
    req_mask  = v.mask;
    req_src_x = v.x;
    req_src_y = v.y;
  endtask

  // One isolated read: low the negedge after accept, valid the negedge after that
  task automatic read_one(input vec_s v, input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    drive_read(v);
    @(negedge clk);
    req_v = 1'b0;
    check({tag, "_lat_low"}, 32'(resp_v), 32'd0);
    @(negedge clk);
    check({tag, "_lat_high"}, 32'(resp_v), 32'd1);
    check({tag, "_data"}, resp_data, v.exp);
    check({tag, "_dst_x"}, 32'(resp_dst_x), 32'(v.x));
    check({tag, "_dst_y"}, 32'(resp_dst_y), 32'(v.y));
    $display("txn %s read addr=%h mask=%h -> data=%h dst=(%0d,%0d)",
             tag, v.addr, v.mask, resp_data, resp_dst_x, resp_dst_y);
  endtask

  initial begin
    int  got;
    bit  drop;

    rst_n = 1'b0; my_x = 6'd2; my_y = 5'd1;
    req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
    req_src_x = '0; req_src_y = '0; resp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_resp_v", 32'(resp_v), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_dst_x", 32'(resp_dst_x), 32'd0);
    check("rst_dst_y", 32'(resp_dst_y), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Single-read table
    vecs[0] = '{28'h000_0002, 4'hF, 6'd3,  5'd4,  32'hDEAD_BEEF};
    vecs[1] = '{28'h000_0001, 4'h5, 6'd5,  5'd6,  32'h0066_0088};
    vecs[2] = '{28'h000_0001, 4'h0, 6'd7,  5'd2,  32'h0000_0000};
    vecs[3] = '{28'h000_0000, 4'hF, 6'd63, 5'd31, 32'h1122_3344};
    vecs[4] = '{28'h000_0003, 4'hF, 6'd1,  5'd1,  32'h0000_0000};
    vecs[5] = '{28'h000_0300, 4'hF, 6'd9,  5'd8,  32'h1122_3344};
    vecs[6] = '{28'h000_0101, 4'h8, 6'd0,  5'd0,  32'h5500_0000};
    vecs[7] = '{28'h000_0002, 4'h6, 6'd12, 5'd13, 32'h00AD_BE00};
    for (int i = 0; i < 8; i++) begin
      read_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back reads, one response per cycle in order
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        check($sformatf("b2b%0d_v", c - 2), 32'(resp_v), 32'd1);
        check($sformatf("b2b%0d_data", c - 2), resp_data, ROM_INIT[(c-2)*32 +: 32]);
        $display("txn b2b%0d data=%h", c - 2, resp_data);
      end
      if (c < 4) drive_read('{AW'(c), 4'hF, 6'(c), 5'(c), 32'h0});
      else req_v = 1'b0;
      @(negedge clk);
    end

    // Backpressure: five accepts fill slot plus FIFO, sixth waits
    bp[0] = '{28'h0, 4'hF, 6'd10, 5'd0, 32'h1122_3344};
    bp[1] = '{28'h1, 4'hF, 6'd11, 5'd1, 32'h5566_7788};
    bp[2] = '{28'h2, 4'hF, 6'd12, 5'd2, 32'hDEAD_BEEF};
    bp[3] = '{28'h3, 4'hF, 6'd13, 5'd3, 32'h0000_0000};
    bp[4] = '{28'h0, 4'h3, 6'd14, 5'd4, 32'h0000_3344};
    bp[5] = '{28'h2, 4'hC, 6'd15, 5'd5, 32'hDEAD_0000};
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd1);
      drive_read(bp[i]);
      @(negedge clk);
    end
    check("bp_full", 32'(req_ready), 32'd0);
    drive_read(bp[5]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_v", 32'(resp_v), 32'd1);
      check("bp_hold_data", resp_data, bp[0].exp);
      check("bp_hold_x", 32'(resp_dst_x), 32'(bp[0].x));
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    got  = 0;
    drop = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (drop) begin
        req_v = 1'b0;
        drop  = 1'b0;
      end
      if (req_v && req_ready) drop = 1'b1;
      if (resp_v) begin
        check($sformatf("bp%0d_data", got), resp_data, bp[got].exp);
        check($sformatf("bp%0d_x", got), 32'(resp_dst_x), 32'(bp[got].x));
        $display("txn bp%0d data=%h dst_x=%0d", got, resp_data, resp_dst_x);
        got++;
      end
      @(negedge clk);
    end
    req_v = 1'b0;
    check("bp_count", 32'(got), 32'd6);

    // Write is dropped and flagged, following read still served
    @(negedge clk);
    req_v = 1'b1; req_we = 1'b1; req_addr = '0; req_mask = 4'hF;
    req_data = 32'hCAFE_F00D; req_src_x = 6'd7; req_src_y = 5'd3;
    @(negedge clk);
    check("wr_err_pre", 32'(wr_err), 32'd0);
    drive_read('{28'h0, 4'hF, 6'd8, 5'd3, 32'h0});
    @(negedge clk);
    req_v = 1'b0;
    check("wr_err_set", 32'(wr_err), 32'd1);
    check("wr_no_resp", 32'(resp_v), 32'd0);
    @(negedge clk);
    check("wr_read_v", 32'(resp_v), 32'd1);
    check("wr_read_data", resp_data, 32'h1122_3344);
    check("wr_read_x", 32'(resp_dst_x), 32'd8);
    $display("txn write addr=0 then read data=%h wr_err=%0d", resp_data, wr_err);
    read_one(vecs[0], "post_wr");
    check("wr_err_sticky", 32'(wr_err), 32'd1);

    // Asynchronous reset in the middle of queued traffic
    @(negedge clk);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_read(bp[i]);
      @(negedge clk);
    end
    req_v = 1'b0;
    check("ar_pre_v", 32'(resp_v), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_resp_v", 32'(resp_v), 32'd0);
    check("ar_wr_err", 32'(wr_err), 32'd0);
    check("ar_data", resp_data, 32'd0);
    check("ar_dst_x", 32'(resp_dst_x), 32'd0);
    check("ar_ready", 32'(req_ready), 32'd1);
    $display("txn async reset asserted mid-traffic");
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_fifo_empty", 32'(resp_v), 32'd0);
    end
    read_one('{28'h3, 4'hF, 6'd4, 5'd9, 32'h0000_0000}, "ar_post");
    check("ar_wr_err_clear", 32'(wr_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
